btn_irq_ctrl: RTL and testbench
===============================

# btn_irq_ctrl

Parametrised interrupt-source conditioner between the board push-buttons (or any slow asynchronous inputs) and the CPU interrupt lines in the board top level. Each of `CHANNELS` inputs is synchronised and debounced, then drives a per-channel interrupt output in one of two modes:
- level-following;
- edge-latched with a pending bit, cleared by acknowledge.

It replaces direct button-to-INT wiring, adding masking, per-channel mode selection and deterministic debounce.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `CHANNELS`, default 5: number of input/interrupt channels, range 1–32.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive cycles an input must hold a new value before it is accepted (10 ms at 100 MHz). Minimum 1.
- `CNT_W`, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width (derived; do not override).

Ports:
- `CLK100MHZ` in 1: system clock.
- `CPU_RESET` in 1: synchronous, active-high reset.
- `BTN_IN` in CHANNELS: raw asynchronous inputs.
- `IRQ_MASK` in CHANNELS: 1 = channel enabled onto `IRQ_OUT`.
- `IRQ_MODE` in CHANNELS: 0 = level, 1 = edge (encoding from package).
- `IRQ_ACK` in CHANNELS: single-cycle pulse; clears the pending bit of edge-mode channels.
- `BTN_STATE` out CHANNELS: debounced input value.
- `IRQ_PENDING` out CHANNELS: pending bits, unmasked.
- `IRQ_OUT` out CHANNELS: `IRQ_PENDING & IRQ_MASK`, routed to the CPU INT inputs.

## Operation
- Per channel, a 2-flop synchroniser on `BTN_IN` produces `sync`.
- Debounce:
  - Counter `cnt` increments on each cycle with `sync != BTN_STATE`.
  - `cnt` resets to 0 on any cycle with `sync == BTN_STATE`.
  - On a mismatch cycle with `cnt == DEBOUNCE_CYCLES-1`: `BTN_STATE <= sync` and `cnt <= 0`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `BTN_STATE`.
- Edge detect: `rise = BTN_STATE & ~BTN_STATE_d` (1-cycle pulse).
- Level mode: pending register `<= BTN_STATE`; `IRQ_ACK` is ignored.
- Edge mode:
  - pending `<=` 1 on `rise`.
  - pending `<=` 0 on `IRQ_ACK`.
  - If `rise` and `IRQ_ACK` occur in the same cycle, set wins and pending stays 1.
- Mode change: on any cycle where `IRQ_MODE` changes, the new mode applies from that cycle.
  - Edge→level: pending follows `BTN_STATE` next cycle.
  - Level→edge: pending holds its current value until acked.
- Masking affects only `IRQ_OUT`. Masked channels still latch pending, so unmasking a pending channel asserts `IRQ_OUT` in the same cycle (combinational AND).
- Channels are fully independent; simultaneous events on different channels are all captured.

## Timing
- Reset values: synchroniser flops, `BTN_STATE`, `BTN_STATE_d`, counters and pending are all 0. Therefore `BTN_STATE`, `IRQ_PENDING` and `IRQ_OUT` read 0 in the first cycle after reset.
- Reset mid-debounce discards the partial count. An input held high through reset is accepted `DEBOUNCE_CYCLES+2` cycles after reset deasserts; in edge mode it then produces one rise.
- Latency from a `BTN_IN` change held stable (sampled at edge 0):
  - `sync` valid at edge 2.
  - `BTN_STATE` updates at edge `DEBOUNCE_CYCLES+2`.
  - pending and `IRQ_OUT` update at edge `DEBOUNCE_CYCLES+3`.
- `IRQ_ACK` sampled at edge n clears pending at edge n (visible after n). `IRQ_OUT` deasserts the same cycle pending clears.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around is possible.

## Configuration
- `BTN_IRQ_BOTH_EDGE_EN`:
  - Defined: edge-mode channels also set pending on the falling edge (`~BTN_STATE & BTN_STATE_d`), so press and release each raise one interrupt.
  - Undefined: rising edge only. Falling-edge logic is not synthesised.
- Level mode is unaffected in both cases.

## Structure
- Package `btn_irq_pkg`:
  - constants `IRQ_MODE_LEVEL` (1'b0) and `IRQ_MODE_EDGE` (1'b1);
  - function `clog2` for `CNT_W`;
  - default `DEBOUNCE_CYCLES` constant.
- Sub-module `btn_debounce`:
  - one channel: synchroniser + counter + `BTN_STATE`;
  - parameters `DEBOUNCE_CYCLES` and `CNT_W`;
  - instantiated `CHANNELS` times via a generate loop.
- Edge detect, pending and mask logic stay in the top.

## Test plan
Bench parameters: `CHANNELS=4`, `DEBOUNCE_CYCLES=4`.
1. Reset, then `BTN_IN=4'b0001` held, `IRQ_MODE=4'b0001`, `IRQ_MASK=4'hF` → `IRQ_OUT[0]` rises exactly 7 cycles after the input edge and stays 1 until `IRQ_ACK[0]` pulse, then 0 the cycle after ack.
2. Glitch: `BTN_IN[1]` high for 3 cycles then low → `BTN_STATE[1]` and `IRQ_OUT[1]` remain 0 throughout.
3. Level mode ch2: input high 20 cycles then low → `IRQ_OUT[2]` high from cycle 7 to cycle 27; `IRQ_ACK[2]` pulses mid-way have no effect.
4. Simultaneous `rise` and `IRQ_ACK` on ch0 → pending stays 1; a second ack one cycle later clears it.
5. `IRQ_MASK=0`, edge on ch3 → `IRQ_PENDING[3]=1`, `IRQ_OUT[3]=0`; set `IRQ_MASK[3]=1` → `IRQ_OUT[3]=1` same cycle.
6. `CPU_RESET` asserted during debounce count 2 of ch0 → all outputs 0; with the input still high, `BTN_STATE[0]` rises 6 cycles after reset release. With `BTN_IRQ_BOTH_EDGE_EN` defined, the release also sets pending.

Source files
------------

// File: rtl/btn_irq_pkg.sv
// Shared constants and helpers for the button interrupt conditioner.
package btn_irq_pkg;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One channel: 2-flop synchroniser followed by a consecutive-cycle debounce counter.
module btn_debounce
    import btn_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            state   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            // stage boundary: synchronised value feeds the debounce counter
            sync_p1 <= sync_p0;
            if (sync_p1 != state) begin
                if (cnt == CNT_LAST) begin
                    state <= sync_p1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/btn_irq_ctrl.sv
// Debounced button interrupt controller with per-channel level/edge mode and mask.
// Optional macro BTN_IRQ_BOTH_EDGE_EN: edge-mode channels also latch on release.
module btn_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int CHANNELS        = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESET,
    input  logic [CHANNELS-1:0] BTN_IN,
    input  logic [CHANNELS-1:0] IRQ_MASK,
    input  logic [CHANNELS-1:0] IRQ_MODE,
    input  logic [CHANNELS-1:0] IRQ_ACK,
    output logic [CHANNELS-1:0] BTN_STATE,
    output logic [CHANNELS-1:0] IRQ_PENDING,
    output logic [CHANNELS-1:0] IRQ_OUT
);

    logic [CHANNELS-1:0] btn_state;
    logic [CHANNELS-1:0] btn_state_p1;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] set_edge;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (CLK100MHZ),
            .rst  (CPU_RESET),
            .btn  (BTN_IN[g]),
            .state(btn_state[g])
        );
    end

    assign rise = btn_state & ~btn_state_p1;

`ifdef BTN_IRQ_BOTH_EDGE_EN
    logic [CHANNELS-1:0] fall;
    assign fall     = ~btn_state & btn_state_p1;
    assign set_edge = rise | fall;
`else
    assign set_edge = rise;
`endif

    // stage boundary: debounced state -> pending register
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            btn_state_p1 <= '0;
            pending      <= '0;
        end else begin
            btn_state_p1 <= btn_state;
            for (int i = 0; i < CHANNELS; i++) begin
                if (IRQ_MODE[i] == IRQ_MODE_LEVEL) begin
                    pending[i] <= btn_state[i];
                end else if (set_edge[i]) begin
                    // a new edge wins over a simultaneous acknowledge
                    pending[i] <= 1'b1;
                end else if (IRQ_ACK[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    assign BTN_STATE   = btn_state;
    assign IRQ_PENDING = pending;
    assign IRQ_OUT     = pending & IRQ_MASK;

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Bench for btn_irq_ctrl: directed vector table, corner sequences, randomized run vs reference model.
module tb_btn_irq_ctrl;
    import btn_irq_pkg::*;

    localparam int CH = 4;
    localparam int D  = 4;
`ifdef BTN_IRQ_BOTH_EDGE_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          CPU_RESET;
    logic [CH-1:0] BTN_IN, IRQ_MASK, IRQ_MODE, IRQ_ACK;
    logic [CH-1:0] BTN_STATE, IRQ_PENDING, IRQ_OUT;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    btn_irq_ctrl #(.CHANNELS(CH), .DEBOUNCE_CYCLES(D)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESET  (CPU_RESET),
        .BTN_IN     (BTN_IN),
        .IRQ_MASK   (IRQ_MASK),
        .IRQ_MODE   (IRQ_MODE),
        .IRQ_ACK    (IRQ_ACK),
        .BTN_STATE  (BTN_STATE),
        .IRQ_PENDING(IRQ_PENDING),
        .IRQ_OUT    (IRQ_OUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: the accepted state flips once the last D synchronised
    // samples all disagree with it; synchroniser is a 2-deep delay line.
    bit m_s1[CH], m_s2[CH], m_st[CH], m_std[CH], m_pend[CH];
    bit win[CH][$];
    bit r_sync, r_nst, r_rise, r_fall, r_opp;

    initial begin
        forever begin
            @(posedge clk);
            for (int c = 0; c < CH; c++) begin
                if (CPU_RESET) begin
                    m_s1[c] = 0; m_s2[c] = 0; m_st[c] = 0; m_std[c] = 0; m_pend[c] = 0;
                    win[c].delete();
                end else begin
                    r_sync  = m_s2[c];
                    m_s2[c] = m_s1[c];
                    m_s1[c] = BTN_IN[c];
                    win[c].push_back(r_sync);
                    if (win[c].size() > D) void'(win[c].pop_front());
                    r_opp = (win[c].size() == D);
                    for (int k = 0; k < win[c].size(); k++)
                        if (win[c][k] == m_st[c]) r_opp = 0;
                    r_nst  = r_opp ? ~m_st[c] : m_st[c];
                    r_rise = m_st[c] & ~m_std[c];
                    r_fall = ~m_st[c] & m_std[c];
                    if (IRQ_MODE[c] == IRQ_MODE_LEVEL) m_pend[c] = m_st[c];
                    else if (r_rise || (BOTH && r_fall)) m_pend[c] = 1;
                    else if (IRQ_ACK[c]) m_pend[c] = 0;
                    m_std[c] = m_st[c];
                    m_st[c]  = r_nst;
                end
            end
        end
    end

    logic [CH-1:0] e_st, e_pd;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (chk_en) begin
                for (int c = 0; c < CH; c++) begin
                    e_st[c] = m_st[c];
                    e_pd[c] = m_pend[c];
                end
                chk("model_state", BTN_STATE, e_st);
                chk("model_pending", IRQ_PENDING, e_pd);
                chk("model_out", IRQ_OUT, e_pd & IRQ_MASK);
            end
        end
    end

    typedef struct {
        logic [CH-1:0] btn, mask, mode, ack;
        int            cycles;
        logic [CH-1:0] e_state, e_pend, e_out;
    } vec_t;

    vec_t tbl[19];

    initial begin
        //          btn      mask     mode     ack     cyc  state    pend     out
        tbl[0]  = '{4'b0000, 4'b1111, 4'b0001, 4'b0000, 3, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 6, 4'b0001, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0001};
        tbl[3]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 5, 4'b0001, 4'b0001, 4'b0001};
        tbl[4]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0011, 4'b1111, 4'b0001, 4'b0000, 3, 4'b0001, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 8, 4'b0001, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0101, 4'b1111, 4'b0001, 4'b0000, 6, 4'b0101, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0101, 4'b1111, 4'b0001, 4'b0000, 1, 4'b0101, 4'b0100, 4'b0100};
        tbl[9]  = '{4'b0101, 4'b1111, 4'b0001, 4'b0100, 5, 4'b0101, 4'b0100, 4'b0100};
        tbl[10] = '{4'b0101, 4'b1111, 4'b0001, 4'b0100, 8, 4'b0101, 4'b0100, 4'b0100};
        tbl[11] = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 6, 4'b0001, 4'b0100, 4'b0100};
        tbl[12] = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000};
        tbl[13] = '{4'b1001, 4'b0000, 4'b1001, 4'b0000, 7, 4'b1001, 4'b1000, 4'b0000};
        tbl[14] = '{4'b1001, 4'b1000, 4'b1001, 4'b0000, 0, 4'b1001, 4'b1000, 4'b1000};
        tbl[15] = '{4'b1001, 4'b1111, 4'b1001, 4'b1000, 1, 4'b1001, 4'b0000, 4'b0000};
        tbl[16] = '{4'b1001, 4'b1111, 4'b1000, 4'b0000, 1, 4'b1001, 4'b0001, 4'b0001};
        tbl[17] = '{4'b1001, 4'b1111, 4'b1001, 4'b0000, 3, 4'b1001, 4'b0001, 4'b0001};
        tbl[18] = '{4'b1001, 4'b1111, 4'b1001, 4'b0001, 1, 4'b1001, 4'b0000, 4'b0000};

        CPU_RESET = 1'b1;
        BTN_IN = '0; IRQ_MASK = '0; IRQ_MODE = '0; IRQ_ACK = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_en    = 1'b1;
        CPU_RESET = 1'b0;
        @(negedge clk); #1;
        chk("reset_state", BTN_STATE, 4'b0000);
        chk("reset_pending", IRQ_PENDING, 4'b0000);
        chk("reset_out", IRQ_OUT, 4'b0000);

        for (int i = 0; i < 19; i++) begin
            BTN_IN = tbl[i].btn; IRQ_MASK = tbl[i].mask;
            IRQ_MODE = tbl[i].mode; IRQ_ACK = tbl[i].ack;
            if (tbl[i].cycles > 0) begin
                @(negedge clk); #1;
                IRQ_ACK = '0;
                repeat (tbl[i].cycles - 1) @(negedge clk);
                if (tbl[i].cycles > 1) #1;
            end else begin
                #1;
            end
            chk($sformatf("vec%0d_state", i), BTN_STATE, tbl[i].e_state);
            chk($sformatf("vec%0d_pending", i), IRQ_PENDING, tbl[i].e_pend);
            chk($sformatf("vec%0d_out", i), IRQ_OUT, tbl[i].e_out);
            if (tbl[i].cycles == 0) begin
                @(negedge clk); #1;
            end
        end

        // Rise and acknowledge in the same cycle on ch0
        BTN_IN = 4'b1000;
        repeat (8) @(negedge clk); #1;
        IRQ_ACK = 4'b1001;
        @(negedge clk); #1;
        IRQ_ACK = '0;
        BTN_IN  = 4'b1001;
        repeat (6) @(negedge clk); #1;
        chk("sim_pre_state", BTN_STATE & 4'b0001, 4'b0001);
        chk("sim_pre_pending", IRQ_PENDING & 4'b0001, 4'b0000);
        IRQ_ACK = 4'b0001;
        @(negedge clk); #1;
        IRQ_ACK = 4'b0001;
        chk("sim_set_wins", IRQ_PENDING & 4'b0001, 4'b0001);
        @(negedge clk); #1;
        IRQ_ACK = '0;
        chk("sim_second_ack", IRQ_PENDING & 4'b0001, 4'b0000);

        // Reset in the middle of a debounce count on ch0
        BTN_IN = 4'b0000;
        repeat (8) @(negedge clk); #1;
        IRQ_ACK = 4'b1001;
        @(negedge clk); #1;
        IRQ_ACK = '0;
        BTN_IN  = 4'b0001;
        repeat (4) @(negedge clk); #1;
        CPU_RESET = 1'b1;
        @(negedge clk); #1;
        chk("rst_mid_state", BTN_STATE, 4'b0000);
        chk("rst_mid_pending", IRQ_PENDING, 4'b0000);
        chk("rst_mid_out", IRQ_OUT, 4'b0000);
        CPU_RESET = 1'b0;
        repeat (5) @(negedge clk); #1;
        chk("rst_hold_state5", BTN_STATE, 4'b0000);
        @(negedge clk); #1;
        chk("rst_hold_state6", BTN_STATE, 4'b0001);
        @(negedge clk); #1;
        chk("rst_hold_pending", IRQ_PENDING, 4'b0001);
        IRQ_ACK = 4'b0001;
        @(negedge clk); #1;
        IRQ_ACK = '0;
        chk("rst_hold_acked", IRQ_PENDING, 4'b0000);
        BTN_IN = 4'b0000;
        repeat (7) @(negedge clk); #1;
        chk("release_state", BTN_STATE, 4'b0000);
        chk("release_pending", IRQ_PENDING, BOTH ? 4'b0001 : 4'b0000);

        // Randomized run against the reference model
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk); #1;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) BTN_IN[c] = ~BTN_IN[c];
                if ($urandom_range(0, 15) == 0) IRQ_MODE[c] = ~IRQ_MODE[c];
                if ($urandom_range(0, 7) == 0) IRQ_MASK[c] = ~IRQ_MASK[c];
                IRQ_ACK[c] = ($urandom_range(0, 3) == 0);
            end
            CPU_RESET = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk); #1;
        CPU_RESET = 1'b0;
        IRQ_ACK   = '0;
        repeat (2) @(negedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
